// File: rtl/shaper_pkg.sv
// Shared definitions for shaper_req_queue and its storage sub-module.
// Contents:
//   StatW        - width of the optional statistics counters
//   count_width  - occupancy counter width for a given FIFO depth
//   stat_cnt_t   - bundle of the saturating push/grant/stall counters
//   sat_inc      - saturating increment used by the statistics counters
package shaper_pkg;

  localparam int unsigned StatW = 32;

  // Occupancy must represent 0..DEPTH inclusive, so one bit more than the pointer.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic [StatW-1:0] push;
    logic [StatW-1:0] grant;
    logic [StatW-1:0] stall;
  } stat_cnt_t;

  // Increment when enabled, sticking at all-ones.
  function automatic logic [StatW-1:0] sat_inc(input logic [StatW-1:0] val, input logic en);
    if (en && (val != '1)) begin
      return val + StatW'(1);
    end
    return val;
  endfunction

endpackage

// File: rtl/shaper_fifo_mem.sv
// Simple dual-port register array backing the shaper request queue.
// One synchronous write port, one combinational read port. Storage is not reset.
// Ports:
//   clk      - clock
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - read address
//   rdata_o  - word at raddr_i (combinational)
module shaper_fifo_mem #(
  parameter int unsigned  DATA_W = 32,
  parameter int unsigned  DEPTH  = 16,
  localparam int unsigned AddrW  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AddrW-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AddrW-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/shaper_req_queue.sv
// Ingress FIFO in front of token_bucket. Words pushed on a valid/ready handshake are held
// until the bucket grants; each grant pops the head and emits it as a registered 1-cycle pulse.
// Optional build macro: SHAPER_STATS_EN adds push/grant/stall counters and peak occupancy.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid_i/in_data_i - producer word; in_ready_o = room available
//   req_o / grant_i      - request to / grant from token_bucket
//   out_valid_o/_data_o  - granted word, one cycle after its grant
//   count_o, afull_o     - occupancy and almost-full (count >= AFULL_THRESH)
//   err_grant_o          - sticky: grant seen while not requesting
//   stat_*_o             - statistics (SHAPER_STATS_EN only)
module shaper_req_queue
  import shaper_pkg::*;
#(
  parameter int unsigned  DATA_W       = 32,
  parameter int unsigned  DEPTH        = 16,
  parameter int unsigned  AFULL_THRESH = 12,
  localparam int unsigned CntW         = count_width(DEPTH),
  localparam int unsigned PtrW         = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              req_o,
  input  logic              grant_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CntW-1:0]   count_o,
  output logic              afull_o,
  output logic              err_grant_o
`ifdef SHAPER_STATS_EN
  ,
  output logic [StatW-1:0]  stat_push_o,
  output logic [StatW-1:0]  stat_grant_o,
  output logic [StatW-1:0]  stat_stall_o,
  output logic [CntW-1:0]   stat_maxocc_o
`endif
);

  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] head_word;
  logic              push, pop;

  // Ready and request depend on registered occupancy only, so there is no
  // combinational path from grant_i to in_ready_o.
  assign in_ready_o = (count_q < CntW'(DEPTH));
  assign req_o      = (count_q != '0);
  assign afull_o    = (count_q >= CntW'(AFULL_THRESH));

  assign push = in_valid_i & in_ready_o;
  assign pop  = grant_i & req_o;

  shaper_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_data_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_word)
  );

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q + CntW'(push) - CntW'(pop);
    out_valid_d = pop;
    out_data_d  = out_data_q;
    err_d       = err_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PtrW'(1);
      out_data_d = head_word;
    end
    if (grant_i && !req_o) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign count_o     = count_q;
  assign err_grant_o = err_q;

`ifdef SHAPER_STATS_EN
  stat_cnt_t       stat_q, stat_d;
  logic [CntW-1:0] maxocc_q, maxocc_d;

  always_comb begin
    stat_d.push  = sat_inc(stat_q.push, push);
    stat_d.grant = sat_inc(stat_q.grant, pop);
    stat_d.stall = sat_inc(stat_q.stall, req_o & ~grant_i);
    maxocc_d     = maxocc_q;
    // Track the post-edge occupancy so the peak is visible in the same cycle as count_o.
    if (count_d > maxocc_q) begin
      maxocc_d = count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q   <= '0;
      maxocc_q <= '0;
    end else begin
      stat_q   <= stat_d;
      maxocc_q <= maxocc_d;
    end
  end

  assign stat_push_o   = stat_q.push;
  assign stat_grant_o  = stat_q.grant;
  assign stat_stall_o  = stat_q.stall;
  assign stat_maxocc_o = maxocc_q;
`endif

endmodule

// File: tb/tb_shaper_req_queue.sv
// Self-checking bench for shaper_req_queue with a scoreboard of pushed words and a small
// occupancy model; the last scenario chains the queue to a behavioural token bucket.
module tb_shaper_req_queue;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;
  localparam int CW    = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          req;
  logic          grant;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [CW-1:0] count;
  logic          afull;
  logic          err_grant;
`ifdef SHAPER_STATS_EN
  logic [31:0]   stat_push;
  logic [31:0]   stat_grant;
  logic [31:0]   stat_stall;
  logic [CW-1:0] stat_maxocc;
`endif

  shaper_req_queue #(
    .DATA_W       (DW),
    .DEPTH        (DEPTH),
    .AFULL_THRESH (AFULL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready),
    .req_o       (req),
    .grant_i     (grant),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .count_o     (count),
    .afull_o     (afull),
    .err_grant_o (err_grant)
`ifdef SHAPER_STATS_EN
    ,
    .stat_push_o   (stat_push),
    .stat_grant_o  (stat_grant),
    .stat_stall_o  (stat_stall),
    .stat_maxocc_o (stat_maxocc)
`endif
  );

  always #5 clk = ~clk;

  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] sb [$];
  int            m_count;
  logic          m_err;
  logic          m_pop;
  int            m_pushes;
  int            m_pops;
  int            m_stalls;

  task automatic model_reset();
    m_count  = 0;
    m_err    = 1'b0;
    m_pop    = 1'b0;
    m_pushes = 0;
    m_pops   = 0;
    m_stalls = 0;
    sb.delete();
  endtask

  // Apply one cycle of stimulus (called at a falling edge), update the model, and return at
  // the next falling edge with the DUT outputs settled.
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic g);
    logic p_push, p_pop;
    in_valid = v;
    in_data  = d;
    grant    = g;
    p_push   = v && (m_count < DEPTH);
    p_pop    = g && (m_count != 0);
    if (g && m_count == 0) m_err = 1'b1;
    if (m_count != 0 && !g) m_stalls++;
    if (p_push) begin
      sb.push_back(d);
      m_pushes++;
    end
    if (p_pop) m_pops++;
    m_count = m_count + int'(p_push) - int'(p_pop);
    m_pop   = p_pop;
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_data  = '0;
    grant    = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_vec += 5;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", in_ready); end
    if (req !== 1'b0) begin n_err++; $display("FAIL reset_req got %b want 0", req); end
    if (count !== '0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_oval got %b want 0", out_valid); end
    if (err_grant !== 1'b0) begin n_err++; $display("FAIL reset_err got %b want 0", err_grant); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, DW'(32'h100 + i), 1'b0);
      n_vec += 4;
      if (count !== CW'(m_count)) begin
        n_err++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count, m_count);
      end
      if (afull !== (m_count >= AFULL)) begin
        n_err++; $display("FAIL fill_afull[%0d] got %b want %b", i, afull, m_count >= AFULL);
      end
      if (in_ready !== (m_count < DEPTH)) begin
        n_err++; $display("FAIL fill_ready[%0d] got %b want %b", i, in_ready, m_count < DEPTH);
      end
      if (out_valid !== 1'b0) begin
        n_err++; $display("FAIL fill_oval[%0d] got %b want 0", i, out_valid);
      end
    end
    n_vec++;
    if (count !== CW'(16)) begin n_err++; $display("FAIL fill_full got %0d want 16", count); end
  endtask

  task automatic test_drain();
    logic [DW-1:0] exp_w;
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, '0, 1'b1);
      n_vec++;
      if (out_valid !== m_pop) begin
        n_err++; $display("FAIL drain_oval[%0d] got %b want %b", i, out_valid, m_pop);
      end
      if (out_valid === 1'b1) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL drain_data[%0d] got %h want nothing", i, out_data);
        end else begin
          exp_w = sb.pop_front();
          if (out_data !== exp_w) begin
            n_err++; $display("FAIL drain_data[%0d] got %h want %h", i, out_data, exp_w);
          end
        end
      end
    end
    drive(1'b0, '0, 1'b0);
    n_vec += 3;
    if (req !== 1'b0) begin n_err++; $display("FAIL drain_req got %b want 0", req); end
    if (count !== '0) begin n_err++; $display("FAIL drain_count got %0d want 0", count); end
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_idle got %b want 0", out_valid); end
  endtask

  task automatic test_stream();
    logic [DW-1:0] exp_w;
    int            seq = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, DW'(32'h500 + seq), 1'b0);
      seq++;
    end
    for (int i = 0; i < 50; i++) begin
      logic v;
      v = (i < 45);
      drive(v, DW'(32'h500 + seq), 1'b1);
      if (v) seq++;
      n_vec += 2;
      if (count !== CW'(m_count)) begin
        n_err++; $display("FAIL stream_count[%0d] got %0d want %0d", i, count, m_count);
      end
      if (out_valid !== m_pop) begin
        n_err++; $display("FAIL stream_oval[%0d] got %b want %b", i, out_valid, m_pop);
      end
      if (out_valid === 1'b1) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL stream_data[%0d] got %h want nothing", i, out_data);
        end else begin
          exp_w = sb.pop_front();
          if (out_data !== exp_w) begin
            n_err++; $display("FAIL stream_data[%0d] got %h want %h", i, out_data, exp_w);
          end
        end
      end
    end
    n_vec++;
    if (sb.size() != 0) begin n_err++; $display("FAIL stream_left got %0d want 0", sb.size()); end
  endtask

  task automatic test_spurious();
    drive(1'b0, '0, 1'b1);
    n_vec += 2;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL spur_oval got %b want 0", out_valid); end
    if (err_grant !== m_err) begin
      n_err++; $display("FAIL spur_err got %b want %b", err_grant, m_err);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, DW'(32'h700 + i), 1'b0);
      n_vec++;
      if (err_grant !== 1'b1) begin
        n_err++; $display("FAIL spur_sticky[%0d] got %b want 1", i, err_grant);
      end
    end
    do_reset();
    n_vec++;
    if (err_grant !== 1'b0) begin n_err++; $display("FAIL spur_clear got %b want 0", err_grant); end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] exp_w;
    for (int i = 0; i < 3; i++) drive(1'b1, DW'(32'h900 + i), 1'b0);
    exp_w    = sb[0];
    in_valid = 1'b0;
    grant    = 1'b1;
    @(posedge clk);
    #2;
    n_vec += 2;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL mid_oval got %b want 1", out_valid); end
    if (out_data !== exp_w) begin
      n_err++; $display("FAIL mid_data got %h want %h", out_data, exp_w);
    end
    rst_n = 1'b0;
    #1;
    n_vec += 3;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_drop got %b want 0", out_valid); end
    if (count !== '0) begin n_err++; $display("FAIL mid_count got %0d want 0", count); end
    if (req !== 1'b0) begin n_err++; $display("FAIL mid_req got %b want 0", req); end
    grant = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_chain();
    logic [DW-1:0] exp_w;
    int            tok = 128;
    int            first [8];
    int            n_first = 0;
    int            win = 0;
    int            max_cnt = 0;
    do_reset();
    for (int i = 0; i < 200; i++) begin
      logic g;
      g   = (m_count != 0) && (tok >= 16);
      tok = tok - (g ? 16 : 0) + 3;
      if (tok > 128) tok = 128;
      drive(1'b1, DW'(32'h2000 + i), g);
      n_vec++;
      if (out_valid !== m_pop) begin
        n_err++; $display("FAIL chain_oval[%0d] got %b want %b", i, out_valid, m_pop);
      end
      if (out_valid === 1'b1) begin
        if (n_first < 8) begin
          first[n_first] = i;
          n_first++;
        end
        if (i >= 40) win++;
        n_vec++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL chain_data[%0d] got %h want nothing", i, out_data);
        end else begin
          exp_w = sb.pop_front();
          if (out_data !== exp_w) begin
            n_err++; $display("FAIL chain_data[%0d] got %h want %h", i, out_data, exp_w);
          end
        end
      end
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
    n_vec += 4;
    if (n_first != 8 || first[7] - first[0] != 7) begin
      n_err++; $display("FAIL chain_burst got %0d outputs span %0d want 8 span 7",
                        n_first, first[7] - first[0]);
    end
    if (win < 29 || win > 31) begin
      n_err++; $display("FAIL chain_rate got %0d want 29..31", win);
    end
    if (max_cnt != 16) begin n_err++; $display("FAIL chain_maxcnt got %0d want 16", max_cnt); end
    if (count !== CW'(m_count)) begin
      n_err++; $display("FAIL chain_count got %0d want %0d", count, m_count);
    end
`ifdef SHAPER_STATS_EN
    n_vec += 5;
    if (stat_push !== 32'(m_pushes)) begin
      n_err++; $display("FAIL stat_push got %0d want %0d", stat_push, m_pushes);
    end
    if (stat_grant !== 32'(m_pops)) begin
      n_err++; $display("FAIL stat_grant got %0d want %0d", stat_grant, m_pops);
    end
    if (stat_push - stat_grant !== 32'(m_count)) begin
      n_err++; $display("FAIL stat_diff got %0d want %0d", stat_push - stat_grant, m_count);
    end
    if (stat_stall !== 32'(m_stalls)) begin
      n_err++; $display("FAIL stat_stall got %0d want %0d", stat_stall, m_stalls);
    end
    if (stat_maxocc !== CW'(16)) begin
      n_err++; $display("FAIL stat_maxocc got %0d want 16", stat_maxocc);
    end
`endif
  endtask

  initial begin
    in_valid = 1'b0;
    in_data  = '0;
    grant    = 1'b0;
    rst_n    = 1'b0;
    model_reset();
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_spurious();
    test_reset_mid();
    test_chain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shaper_req_queue.md
Name: shaper_req_queue

Overview:
- Ingress buffer that sits directly upstream of token_bucket.
- Accepts payload words from a producer on a valid/ready handshake and holds them in a FIFO.
- Presents a request to the bucket while any word is queued; on each grant, pops the head and emits it downstream as a registered one-cycle pulse.
- Decouples bursty producers from the shaped grant rate and exposes occupancy for flow-control monitoring.

Parameters:
- DATA_W, 32, payload width in bits.
- DEPTH, 16, FIFO entries; power of 2, minimum 2.
- AFULL_THRESH, 12, afull_o asserts when count >= this value; range 1..DEPTH.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid_i  in  1  producer has a word.
- in_data_i  in  DATA_W  producer payload.
- in_ready_o  out  1  queue can accept; a push occurs when in_valid_i && in_ready_o.
- req_o  out  1  request to token_bucket req_i.
- grant_i  in  1  grant from token_bucket grant_o.
- out_valid_o  out  1  one-cycle pulse carrying a granted word.
- out_data_o  out  DATA_W  granted payload; valid only with out_valid_o.
- count_o  out  $clog2(DEPTH)+1  current occupancy.
- afull_o  out  1  count_o >= AFULL_THRESH.
- err_grant_o  out  1  sticky flag: grant_i seen while req_o was low.

Behaviour:
- Reset (async assert, sync release):
  - wr_ptr, rd_ptr and count = 0; out_valid_o = 0; out_data_o = 0; err_grant_o = 0.
  - Hence in_ready_o = 1, req_o = 0, afull_o = 0.
  - FIFO storage is not reset.
- Push:
  - in_ready_o = (count < DEPTH), derived combinationally from registered count only; no combinational path from grant_i.
  - On a push edge, mem[wr_ptr] <= in_data_i and wr_ptr increments.
- Request: req_o = (count != 0), combinational from registered count.
- Pop:
  - At an edge where grant_i && req_o: out_data_o <= mem[rd_ptr], out_valid_o <= 1, rd_ptr increments.
  - Otherwise out_valid_o <= 0 and out_data_o holds.
  - Latency from grant edge to out_valid_o is 1 cycle.
- Pointers: log2(DEPTH) bits; wrap naturally, modulo DEPTH.
- Count update per edge: count + push − pop.
- Simultaneous push and pop:
  - Both occur and count is unchanged.
  - When count = DEPTH, in_ready_o = 0, so no push occurs even if a pop occurs that cycle; the slot frees on the next cycle.
  - Empty plus simultaneous push: no pop (req_o = 0 that cycle). The word is requestable from the next cycle; there is no bypass.
- Spurious grant (grant_i && !req_o): no pop, no out_valid_o; err_grant_o <= 1, cleared only by reset.
- Reset mid-operation: queued words are discarded and any in-flight out_valid_o drops immediately.
- Downstream has no backpressure; the consumer must accept every out_valid_o pulse.

Optional Feature:
SHAPER_STATS_EN:
- Defined: adds outputs stat_push_o, stat_grant_o and stat_stall_o (32 bits each), plus stat_maxocc_o (count width).
  - stat_push_o counts pushes; stat_grant_o counts pops.
  - stat_stall_o counts cycles with req_o && !grant_i.
  - stat_maxocc_o is the peak count since reset.
  - All four reset to 0; the 32-bit counters saturate at all-ones.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package shaper_pkg holds:
  - localparam for the count width function;
  - a stat-counter width constant (32);
  - a typedef for the stats bundle.
- One sub-module, shaper_fifo_mem: a simple dual-port register array with write enable/address/data and a read address, returning the selected word combinationally. Control, pointers and output register remain in shaper_req_queue.

Test Plan:
- Reset, then idle → in_ready_o = 1, req_o = 0, count_o = 0, out_valid_o = 0, err_grant_o = 0.
- Push 16 words (0x100..0x10F), grant_i = 0 → count_o = 16, in_ready_o = 0, afull_o = 1 from count 12; a 17th in_valid_i is not accepted.
- With queue full, hold grant_i = 1 for 16 cycles → out_valid_o on 16 consecutive cycles carrying 0x100..0x10F in order, each one cycle after its grant; req_o = 0 and count_o = 0 after.
- Continuous push every cycle with grant_i = 1 every cycle from count = 5 → count_o stays 5; output order matches push order across pointer wrap (≥ 40 words).
- grant_i = 1 while empty → no out_valid_o; err_grant_o = 1 and stays 1 until rst_n is pulsed low.
- Chain to token_bucket (DEN = 16, RATE_NUM = 3, BURST_MAX = 8) with producer pushing every cycle for 200 cycles:
  - 8 back-to-back outputs after reset;
  - then long-run output rate of 3/16 per cycle, within ±1 word;
  - count_o saturates at 16;
  - with SHAPER_STATS_EN defined, stat_push_o − stat_grant_o equals final count_o.
